// File: rtl/result_accum_pkg.sv
// Shared types and helpers for the windowed result accumulator.
package result_accum_pkg;

    localparam int SAMPLE_W = 9;

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

    // Width needed to hold a sample count from 0 up to and including win.
    function automatic int cnt_width(input int win);
        return $clog2(win + 1);
    endfunction

endpackage

// File: rtl/sat_add.sv
// ACC_W-wide signed adder; clamps to the signed range when RESULT_ACCUM_SAT_EN is defined,
// otherwise wraps and reports no overflow.
module sat_add #(
    parameter int ACC_W = 12
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

    logic [ACC_W-1:0] raw_s;

    assign raw_s = a + b;

`ifdef RESULT_ACCUM_SAT_EN
    // Overflow only when both operands share a sign the result does not.
    always_comb begin
        ovf = (a[ACC_W-1] == b[ACC_W-1]) && (raw_s[ACC_W-1] != a[ACC_W-1]);
        if (ovf) begin
            if (a[ACC_W-1]) begin
                sum = {1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                sum = {1'b0, {(ACC_W-1){1'b1}}};
            end
        end else begin
            sum = raw_s;
        end
    end
`else
    assign sum = raw_s;
    assign ovf = 1'b0;
`endif

endmodule

// File: rtl/result_accum.sv
// Windowed signed accumulator: sums WIN samples (or a flushed partial window) and
// presents the result on a registered valid/ready port. Saturation: RESULT_ACCUM_SAT_EN.
module result_accum
    import result_accum_pkg::*;
#(
    parameter int  WIN   = 4,
    parameter int  ACC_W = 12,
    localparam int CNT_W = cnt_width(WIN)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SAMPLE_W-1:0]  in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 flush,
    output logic [ACC_W-1:0]     out_data,
    output logic [CNT_W-1:0]     out_cnt,
    output logic                 out_sat,
    output logic                 out_valid,
    input  logic                 out_ready
);

    state_e           state_r;
    state_e           state_next_s;
    logic [ACC_W-1:0] acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic             sat_r;
    logic [ACC_W-1:0] out_data_r;
    logic [CNT_W-1:0] out_cnt_r;
    logic             out_sat_r;
    logic             out_valid_r;

    logic [ACC_W-1:0] samp_ext_s;
    logic [ACC_W-1:0] sum_s;
    logic             ovf_s;
    logic             accept_s;
    logic             close_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic [ACC_W-1:0] acc_next_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic             sat_next_s;

    assign samp_ext_s = ACC_W'($signed(in_data));
    assign cnt_inc_s  = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};

    sat_add #(.ACC_W(ACC_W)) u_sat_add (
        .a   (acc_r),
        .b   (samp_ext_s),
        .sum (sum_s),
        .ovf (ovf_s)
    );

    assign in_ready  = (state_r == ST_ACCUM);
    assign out_data  = out_data_r;
    assign out_cnt   = out_cnt_r;
    assign out_sat   = out_sat_r;
    assign out_valid = out_valid_r;

    // Next-state decode plus the window update that would land on this edge.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        close_s      = 1'b0;
        acc_next_s   = acc_r;
        cnt_next_s   = cnt_r;
        sat_next_s   = sat_r;
        case (state_r)
            ST_ACCUM: begin
                accept_s = in_valid;
                if (accept_s) begin
                    acc_next_s = sum_s;
                    cnt_next_s = cnt_inc_s;
                    sat_next_s = sat_r | ovf_s;
                end else begin
                    acc_next_s = acc_r;
                end
                close_s = (accept_s && (cnt_inc_s == CNT_W'(WIN)))
                       || (flush && ((cnt_r != {CNT_W{1'b0}}) || accept_s));
                if (close_s) begin
                    state_next_s = ST_HOLD;
                end else begin
                    state_next_s = ST_ACCUM;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_next_s = ST_ACCUM;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            default: begin
                state_next_s = ST_ACCUM;
            end
        endcase
    end

    // State, window accumulator and output word registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_ACCUM;
            acc_r       <= {ACC_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            sat_r       <= 1'b0;
            out_data_r  <= {ACC_W{1'b0}};
            out_cnt_r   <= {CNT_W{1'b0}};
            out_sat_r   <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (state_r == ST_ACCUM) begin
                acc_r <= acc_next_s;
                cnt_r <= cnt_next_s;
                sat_r <= sat_next_s;
                if (close_s) begin
                    out_data_r  <= acc_next_s;
                    out_cnt_r   <= cnt_next_s;
                    out_sat_r   <= sat_next_s;
                    out_valid_r <= 1'b1;
                end
            end else if (out_ready) begin
                // Handshake completes: free the window for the next sample.
                out_valid_r <= 1'b0;
                acc_r       <= {ACC_W{1'b0}};
                cnt_r       <= {CNT_W{1'b0}};
                sat_r       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_result_accum.sv
// Randomized scoreboard bench for result_accum (WIN=4, ACC_W=10); follows RESULT_ACCUM_SAT_EN.
module tb_result_accum;

    localparam int WIN   = 4;
    localparam int ACC_W = 10;
    localparam int CNT_W = $clog2(WIN + 1);
    localparam int MAXV  = (1 << (ACC_W - 1)) - 1;
    localparam int MINV  = -(1 << (ACC_W - 1));

    typedef struct {
        int sum;
        int cnt;
        int sat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [8:0]       in_data = 9'd0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             flush = 1'b0;
    logic [ACC_W-1:0] out_data;
    logic [CNT_W-1:0] out_cnt;
    logic             out_sat;
    logic             out_valid;
    logic             out_ready = 1'b0;

    int compared   = 0;
    int mismatched = 0;

    exp_t exp_q[$];
    int   win_q[$];
    bit   m_hold = 1'b0;

    result_accum #(.WIN(WIN), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_data  (out_data),
        .out_cnt   (out_cnt),
        .out_sat   (out_sat),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: fold the window's samples with plain integer arithmetic.
    function automatic exp_t close_window();
        exp_t e;
        e.sum = 0;
        e.sat = 0;
        foreach (win_q[i]) begin
            int t;
            t = e.sum + win_q[i];
`ifdef RESULT_ACCUM_SAT_EN
            if (t > MAXV) begin
                t = MAXV;
                e.sat = 1;
            end
            if (t < MINV) begin
                t = MINV;
                e.sat = 1;
            end
`else
            t = t & ((1 << ACC_W) - 1);
            if (t > MAXV) t = t - (1 << ACC_W);
`endif
            e.sum = t;
        end
        e.cnt = win_q.size();
        return e;
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, then check the control outputs.
    task automatic cyc(input bit v, input int d, input bit f, input bit o, input bit r);
        logic [8:0] d9;
        d9        = 9'(d);
        in_valid  = v;
        in_data   = d9;
        flush     = f;
        out_ready = o;
        rst       = r;
        if (r) begin
            m_hold = 1'b0;
            win_q.delete();
            exp_q.delete();
        end else if (m_hold) begin
            if (o) m_hold = 1'b0;
        end else begin
            if (v) win_q.push_back(int'($signed(d9)));
            if ((v && win_q.size() == WIN) || (f && win_q.size() > 0)) begin
                exp_q.push_back(close_window());
                win_q.delete();
                m_hold = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check("in_ready", in_ready, !m_hold);
        check("out_valid", out_valid, m_hold);
    endtask

    // Monitor: at each handshake pop the scoreboard; while stalled, the word must not move.
    bit         held_p = 1'b0;
    logic [ACC_W-1:0] held_data;
    logic [CNT_W-1:0] held_cnt;
    logic             held_sat;
    always @(negedge clk) begin
        if (rst) begin
            held_p = 1'b0;
        end else begin
            if (held_p && out_valid) begin
                check("hold_data", out_data, held_data);
                check("hold_cnt", out_cnt, held_cnt);
                check("hold_sat", out_sat, held_sat);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_data", longint'($signed(out_data)), e.sum);
                    check("out_cnt", out_cnt, e.cnt);
                    check("out_sat", out_sat, e.sat);
                end
            end
            held_p    = out_valid && !out_ready;
            held_data = out_data;
            held_cnt  = out_cnt;
            held_sat  = out_sat;
        end
    end

    initial begin
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 7, 1'b0, 1'b1, 1'b1);
        check("rst_out_data", out_data, 0);
        check("rst_out_cnt", out_cnt, 0);
        check("rst_out_sat", out_sat, 0);

        // Basic full window.
        cyc(1'b1, 10, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, -3, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 100, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, -200, 1'b0, 1'b1, 1'b0);
        check("direct_sum", longint'($signed(out_data)), -93);
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);

        // Overflow: wraps to -4 or clamps to 511.
        for (int i = 0; i < 4; i++) cyc(1'b1, 255, 1'b0, 1'b1, 1'b0);
`ifdef RESULT_ACCUM_SAT_EN
        check("ovf_sum", longint'($signed(out_data)), 511);
`else
        check("ovf_sum", longint'($signed(out_data)), -4);
`endif
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);

        // Flush alone, then an empty flush that must be ignored.
        cyc(1'b1, 5, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 7, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);

        // Flush together with an accepted sample.
        cyc(1'b1, 1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 2, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 3, 1'b1, 1'b1, 1'b0);
        check("flush_cnt", out_cnt, 3);
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);

        // Back-pressure: held word, pending sample taken after the handshake.
        for (int i = 0; i < 4; i++) cyc(1'b1, 20 + i, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 9, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 9, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 9, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);

        // Reset discards a partial window.
        cyc(1'b1, 50, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 60, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 70, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1, 1'b0, 1'b1, 1'b0);
        check("post_rst_sum", longint'($signed(out_data)), 4);
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            bit v, f, o, r;
            int d;
            v = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 7) == 0);
            o = ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 99) == 0);
            case ($urandom_range(0, 3))
                0: d = 255;
                1: d = -256;
                default: d = $urandom_range(0, 511) - 256;
            endcase
            cyc(v, d, f, o, r);
        end

        for (int i = 0; i < 3; i++) cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
